// File: rtl/puf_ctrl_pkg.sv
// Shared types and widths for the PUF challenge sequencer.
// Holds the FSM state encoding and subblock bus widths.
package puf_ctrl_pkg;

  localparam int CHAL_W = 8;
  localparam int EN_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RACE,
    CAPTURE,
    FINISH
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous PUF status bit.
// Clears on the synchronous active-low reset.
module sync_2ff (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock) begin
    if (!reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/puf_challenge_sequencer.sv
// Steps a PUF subblock through clear/race/capture per challenge
// and collects one response bit per challenge, with race timeout.
module puf_challenge_sequencer
  import puf_ctrl_pkg::*;
#(
  parameter int NUM_BITS       = 16,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 2**20
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [CHAL_W-1:0]   challenge_seed,
  input  logic                puf_out,
  input  logic                puf_done,
  output logic [CHAL_W-1:0]   puf_challenge,
  output logic [EN_W-1:0]     puf_enable,
  output logic                puf_reset,
  output logic                busy,
  output logic                valid,
  output logic [NUM_BITS-1:0] response,
  output logic                timeout
);

  localparam int SW =
    (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int TW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int IW =
    (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

  localparam logic [SW-1:0] SET_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [IW-1:0] I_LAST   = IW'(NUM_BITS - 1);

  state_t            state;
  state_t            next;
  logic [CHAL_W-1:0] seed;
  logic [IW-1:0]     idx;
  logic [SW-1:0]     set_cnt;
  logic [TW-1:0]     race_cnt;
  logic              done_s;
  logic              out_s;

  sync_2ff u_sync_done (
    .clock (clock),
    .reset (reset),
    .d     (puf_done),
    .q     (done_s)
  );

  sync_2ff u_sync_out (
    .clock (clock),
    .reset (reset),
    .d     (puf_out),
    .q     (out_s)
  );

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= next;
  end

  always_comb begin
    next          = state;
    busy          = 1'b1;
    valid         = 1'b0;
    puf_reset     = 1'b0;
    puf_enable    = '0;
    puf_challenge = seed + CHAL_W'(idx);
    unique case (state)
      IDLE: begin
        busy          = 1'b0;
        puf_reset     = 1'b1;
        puf_challenge = '0;
        if (start) next = CLEAR;
      end
      CLEAR: begin
        puf_reset = 1'b1;
        if (set_cnt == SET_LAST) next = RACE;
      end
      RACE: begin
        puf_enable = '1;
        // a completed race beats a coincident timeout
        if (done_s)                  next = CAPTURE;
        else if (race_cnt == TO_LAST) next = FINISH;
      end
      CAPTURE: begin
        next = (idx == I_LAST) ? FINISH : CLEAR;
      end
      FINISH: begin
        valid     = 1'b1;
        puf_reset = 1'b1;
        next      = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      seed     <= '0;
      idx      <= '0;
      set_cnt  <= '0;
      race_cnt <= '0;
      response <= '0;
      timeout  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            seed     <= challenge_seed;
            idx      <= '0;
            set_cnt  <= '0;
            response <= '0;
            timeout  <= 1'b0;
          end
        end
        CLEAR: begin
          race_cnt <= '0;
          if (set_cnt == SET_LAST) set_cnt <= '0;
          else                     set_cnt <= set_cnt + 1'b1;
        end
        RACE: begin
          race_cnt <= race_cnt + 1'b1;
          if (!done_s && race_cnt == TO_LAST) timeout <= 1'b1;
        end
        CAPTURE: begin
          response[idx] <= out_s;
          if (idx != I_LAST) idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Randomized bench for puf_challenge_sequencer with a
// behavioural PUF subblock and per-run expected response.
module tb_puf_challenge_sequencer;

  localparam int NB = 4;
  localparam int ST = 4;
  localparam int TO = 64;
  localparam logic [31:0] ALL1 = 32'hFFFF_FFFF;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    challenge_seed = '0;
  logic          puf_out = 1'b0;
  logic          puf_done = 1'b0;
  logic [7:0]    puf_challenge;
  logic [31:0]   puf_enable;
  logic          puf_reset;
  logic          busy;
  logic          valid;
  logic [NB-1:0] response;
  logic          timeout;

  always #5 clock = ~clock;

  puf_challenge_sequencer #(
    .NUM_BITS       (NB),
    .SETTLE_CYCLES  (ST),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .challenge_seed (challenge_seed),
    .puf_out        (puf_out),
    .puf_done       (puf_done),
    .puf_challenge  (puf_challenge),
    .puf_enable     (puf_enable),
    .puf_reset      (puf_reset),
    .busy           (busy),
    .valid          (valid),
    .response       (response),
    .timeout        (timeout)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  bit         tab [256];
  int         delay = 10;
  int         hang_idx = 99;
  int         rises = 0;
  int         clear_cnt = 0;
  int         en_cnt = 0;
  int         last_len = 0;
  int         nvalid = 0;
  int         viol = 0;
  int         race_cyc = 0;
  bit         prev_en = 1'b0;
  logic [7:0] chals [$];

  // monitor plus PUF subblock model, both on the falling edge
  always @(negedge clock) begin
    if (puf_enable == ALL1 && !prev_en) begin
      chals.push_back(puf_challenge);
      rises++;
      check("settle_len", 64'(clear_cnt), 64'(ST));
    end
    if (busy && puf_reset && !valid) clear_cnt++;
    else clear_cnt = 0;
    if (puf_reset && puf_enable != 0) viol++;
    if (puf_enable != 0 && puf_enable != ALL1) viol++;
    if (puf_enable == ALL1) en_cnt++;
    else begin
      if (en_cnt != 0) last_len = en_cnt;
      en_cnt = 0;
    end
    if (valid) nvalid++;
    prev_en = (puf_enable == ALL1);
    if (puf_reset || puf_enable != ALL1) begin
      puf_done = 1'b0;
      race_cyc = 0;
    end else begin
      race_cyc++;
      if (race_cyc >= delay && rises - 1 != hang_idx) begin
        puf_out  = tab[puf_challenge];
        puf_done = 1'b1;
      end
    end
  end

  task automatic run_one(input logic [7:0] seed, input int hang,
                         input int d, input bit poke);
    int            base;
    int            n;
    bit            got;
    logic [NB-1:0] exp;
    logic [7:0]    cc;
    bit            to_exp;
    to_exp = (hang < NB);
    for (int k = 0; k < NB; k++) begin
      cc = seed + 8'(k);
      exp[k] = (to_exp && k >= hang) ? 1'b0 : tab[cc];
    end
    n = to_exp ? hang + 1 : NB;
    hang_idx = hang;
    delay = d;
    chals.delete();
    rises = 0;
    base = nvalid;
    @(negedge clock);
    start = 1'b1;
    challenge_seed = seed;
    @(negedge clock);
    start = 1'b0;
    challenge_seed = ~seed;
    #1;
    check("busy_start", 64'(busy), 64'(1));
    check("to_cleared", 64'(timeout), 64'(0));
    got = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      #1;
      if (valid) begin
        got = 1'b1;
        break;
      end
      if (poke && c == 8) begin
        start = 1'b1;
        challenge_seed = 8'h5A;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check("valid_seen", 64'(got), 64'(1));
    check("response", 64'(response), 64'(exp));
    check("timeout", 64'(timeout), 64'(to_exp));
    check("busy_finish", 64'(busy), 64'(1));
    if (to_exp) check("race_len", 64'(last_len), 64'(TO));
    check("n_chal", 64'(chals.size()), 64'(n));
    for (int k = 0; k < n && k < chals.size(); k++) begin
      cc = seed + 8'(k);
      check("challenge", 64'(chals[k]), 64'(cc));
    end
    repeat (3) @(negedge clock);
    #1;
    check("idle_busy", 64'(busy), 64'(0));
    check("idle_preset", 64'(puf_reset), 64'(1));
    check("idle_chal", 64'(puf_challenge), 64'(0));
    check("hold_resp", 64'(response), 64'(exp));
    check("hold_to", 64'(timeout), 64'(to_exp));
    check("one_valid", 64'(nvalid - base), 64'(1));
  endtask

  initial begin
    int h;
    int base;
    for (int i = 0; i < 256; i++) tab[i] = 1'($urandom_range(0, 1));
    repeat (3) @(negedge clock);
    #1;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_valid", 64'(valid), 64'(0));
    check("rst_preset", 64'(puf_reset), 64'(1));
    check("rst_enable", 64'(puf_enable), 64'(0));
    check("rst_chal", 64'(puf_challenge), 64'(0));
    check("rst_resp", 64'(response), 64'(0));
    check("rst_to", 64'(timeout), 64'(0));
    reset = 1'b1;

    tab[8'h10] = 1'b1;
    tab[8'h11] = 1'b0;
    tab[8'h12] = 1'b1;
    tab[8'h13] = 1'b1;
    run_one(8'h10, 99, 20, 1'b0);
    run_one(8'hFE, 99, 7, 1'b1);
    run_one(8'hFF, 99, 3, 1'b0);
    run_one(8'h33, 2, 12, 1'b0);
    run_one(8'hC0, 0, 5, 1'b1);
    for (int r = 0; r < 10; r++) begin
      h = $urandom_range(0, 9);
      run_one(8'($urandom_range(0, 255)), h,
              $urandom_range(3, 40), 1'($urandom_range(0, 1)));
    end

    tab[8'h80] = 1'b1;
    hang_idx = 99;
    delay = 30;
    chals.delete();
    rises = 0;
    base = nvalid;
    @(negedge clock);
    start = 1'b1;
    challenge_seed = 8'h80;
    @(negedge clock);
    start = 1'b0;
    for (int c = 0; c < 500 && rises < 3; c++) @(negedge clock);
    #1;
    check("third_race", 64'(rises), 64'(3));
    check("pre_rst_resp", 64'(response[1:0]),
          64'({tab[8'h81], tab[8'h80]}));
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    #1;
    check("mid_busy", 64'(busy), 64'(0));
    check("mid_enable", 64'(puf_enable), 64'(0));
    check("mid_preset", 64'(puf_reset), 64'(1));
    check("mid_resp", 64'(response), 64'(0));
    check("mid_valid", 64'(nvalid - base), 64'(0));
    reset = 1'b1;
    run_one(8'h44, 99, 9, 1'b0);

    check("enable_rules", 64'(viol), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
